// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the signed adder arbiter and related
// shared-resource arbiters in the ALU.
package adder_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_e;

    // Round-robin pointer increment with wrap at num_req.
    function automatic int rr_next(input int ptr, input int num_req);
        return (ptr >= num_req - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping
// to 0. Grant is suppressed when en is low; winner/any are always valid.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any
);

    localparam int ID_W = $clog2(NUM_REQ);

    always_comb begin
        int   idx;
        logic found;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
        if (en && found) gnt[winner] = 1'b1;
    end

    assign any = |req;

endmodule

// File: rtl/signed_adder.sv
// Signed adder: sign-extended SIZE+1-bit sum plus SIZE-bit two's-complement
// overflow flag.
module signed_adder #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE:0]   sum,
    output logic            overflow
);

    assign sum = {a[SIZE-1], a} + {b[SIZE-1], b};
    // Overflow of the SIZE-bit result: operands agree in sign, truncated sum does not.
    assign overflow = (a[SIZE-1] == b[SIZE-1]) && (sum[SIZE-1] != a[SIZE-1]);

endmodule

// File: rtl/signed_adder_arb.sv
// Round-robin arbiter sharing one signed_adder among NUM_REQ requesters, with
// a registered valid/ready response holding result, overflow and requester id.
module signed_adder_arb
    import adder_arb_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*SIZE-1:0] a_in,
    input  logic [NUM_REQ*SIZE-1:0] b_in,
    output logic [NUM_REQ-1:0]      gnt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [SIZE:0]           rsp_result,
    output logic                    rsp_overflow
);

    // Response handshake: rsp_valid/rsp_id/rsp_result/rsp_overflow are stable
    // while rsp_valid=1 and rsp_ready=0; the response retires on a cycle with
    // both high, and a new grant may load the registers in that same cycle.

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] winner;
    logic            any_req;
    logic            pick_en;
    logic            accept;
    logic [SIZE-1:0] add_a, add_b;
    logic [SIZE:0]   add_sum;
    logic            add_ovf;

    // Grant is only possible when the response slot is free or being drained.
    assign pick_en = rst_n && ((state_q == IDLE) || rsp_ready);
    assign accept  = any_req && pick_en;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .en     (pick_en),
        .gnt    (gnt),
        .winner (winner),
        .any    (any_req)
    );

    assign add_a = a_in[winner*SIZE +: SIZE];
    assign add_b = b_in[winner*SIZE +: SIZE];

    signed_adder #(.SIZE(SIZE)) u_adder (
        .a        (add_a),
        .b        (add_b),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = RESP;
        else if (state_q == RESP && rsp_ready)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q        <= ID_W'(rr_next(int'(winner), NUM_REQ));
                rsp_id       <= winner;
                rsp_result   <= add_sum;
                rsp_overflow <= add_ovf;
            end
        end
    end

    assign rsp_valid = (state_q == RESP);

endmodule
